// File: rtl/loopyV_data_types.sv
// Shared core data types: funct3 size codes, LSU byte-enable patterns and LSU FSM states.
package loopyV_data_types;

   localparam logic [2:0] FUNCT3_BYTE       = 3'b000;
   localparam logic [2:0] FUNCT3_HALFWORD   = 3'b001;
   localparam logic [2:0] FUNCT3_WORD       = 3'b010;
   localparam logic [2:0] FUNCT3_BYTE_U     = 3'b100;
   localparam logic [2:0] FUNCT3_HALFWORD_U = 3'b101;

   localparam logic [3:0] LSU_BE_BYTE = 4'b0001;
   localparam logic [3:0] LSU_BE_HALF = 4'b0011;
   localparam logic [3:0] LSU_BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } lsu_state_e;

   // Codes the decoder already flags as illegal are serviced as full words.
   function automatic logic [2:0] norm_size(input logic [2:0] f);
      case (f)
         FUNCT3_BYTE, FUNCT3_HALFWORD, FUNCT3_BYTE_U, FUNCT3_HALFWORD_U: norm_size = f;
         default:                                                        norm_size = FUNCT3_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-lane replication,
// load shift and sign/zero extension.
module lsu_align
   import loopyV_data_types::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      be_o    = LSU_BE_WORD;
      wdata_o = wdata_i;
      load_o  = rdata_i;
      byte_v  = 8'(rdata_i >> {addr_lo_i, 3'b000});
      half_v  = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});
      case (size_i)
         FUNCT3_BYTE, FUNCT3_BYTE_U: begin
            be_o    = LSU_BE_BYTE << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            load_o  = (size_i == FUNCT3_BYTE) ? {{24{byte_v[7]}}, byte_v}
                                              : {24'd0, byte_v};
         end
         FUNCT3_HALFWORD, FUNCT3_HALFWORD_U: begin
            be_o    = LSU_BE_HALF << {addr_lo_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            load_o  = (size_i == FUNCT3_HALFWORD) ? {{16{half_v[15]}}, half_v}
                                                  : {16'd0, half_v};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit sequencer for the shared data-memory bus (req/gnt/rvalid).
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of truncating.
module lsu_controller
   import loopyV_data_types::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req_i,
   input  logic              store_req_i,
   input  logic [2:0]        size_sel_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        rd_addr_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   input  logic              mem_err_i,
   output logic              stall_o,
`ifdef MISALIGN_TRAP_EN
   output logic              misalign_o,
`endif
   output logic              wb_valid_o,
   output logic [31:0]       wb_data_o,
   output logic [4:0]        wb_rd_o,
   output logic              lsu_err_o
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [31:0]       wdata_q;
   logic [4:0]        rd_q;
   logic              is_load_q;
   logic [7:0]        cnt_q;

   logic        any_req, misaligned, timeout;
   logic        wb_fire, err_fire;
   logic [3:0]  be;
   logic [31:0] wrep, ld_data;

   assign any_req = load_req_i | store_req_i;
   assign timeout = (cnt_q == TO_LAST) && !mem_rvalid_i;

`ifdef MISALIGN_TRAP_EN
   logic        trap_fire;
   logic [2:0]  size_n;
   assign size_n     = norm_size(size_sel_i);
   assign misaligned = ((size_n == FUNCT3_HALFWORD || size_n == FUNCT3_HALFWORD_U) && addr_i[0])
                    || ((size_n == FUNCT3_WORD) && (addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   lsu_align u_align (
      .size_i    (size_q),
      .addr_lo_i (addr_q[1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (mem_rdata_i),
      .be_o      (be),
      .wdata_o   (wrep),
      .load_o    (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req && !misaligned)      state_d = REQ;
         REQ:     if (mem_gnt_i)                   state_d = WAIT;
         WAIT:    if (mem_rvalid_i || timeout)     state_d = IDLE;
         default:                                  state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      wb_fire     = 1'b0;
      err_fire    = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_fire   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            stall_o = any_req;
`ifdef MISALIGN_TRAP_EN
            trap_fire = any_req && misaligned;
`endif
         end
         REQ: begin
            stall_o     = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = !is_load_q;
            mem_be_o    = be;
            mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata_o = wrep;
         end
         WAIT: begin
            stall_o  = 1'b1;
            wb_fire  = mem_rvalid_i && is_load_q && !mem_err_i;
            err_fire = (mem_rvalid_i && mem_err_i) || timeout;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q     <= '0;
         size_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         is_load_q  <= 1'b0;
         cnt_q      <= '0;
         wb_valid_o <= 1'b0;
         wb_data_o  <= '0;
         wb_rd_o    <= '0;
         lsu_err_o  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         misalign_o <= 1'b0;
`endif
      end else begin
         // Load has priority when decode flags both; the store is dropped.
         if (state_q == IDLE && any_req && !misaligned) begin
            addr_q    <= addr_i;
            size_q    <= norm_size(size_sel_i);
            wdata_q   <= wdata_i;
            rd_q      <= rd_addr_i;
            is_load_q <= load_req_i;
         end
         if (state_q == REQ && mem_gnt_i) cnt_q <= '0;
         else if (state_q == WAIT)        cnt_q <= cnt_q + 8'd1;
         wb_valid_o <= wb_fire;
         if (wb_fire) begin
            wb_data_o <= ld_data;
            wb_rd_o   <= rd_q;
         end
         lsu_err_o <= err_fire;
`ifdef MISALIGN_TRAP_EN
         misalign_o <= trap_fire;
`endif
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: expected writebacks/faults queued at issue,
// compared when the DUT pulses wb_valid_o or lsu_err_o.
module tb_lsu_controller;

   localparam int unsigned TO_CYC = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_req_i, store_req_i;
   logic [2:0]  size_sel_i;
   logic [31:0] addr_i, wdata_i;
   logic [4:0]  rd_addr_i;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic        lsu_err_o;

   typedef struct {
      logic        is_err;
      logic [31:0] data;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   lsu_controller #(.TIMEOUT_CYC(TO_CYC), .ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_req_i   (load_req_i),
      .store_req_i  (store_req_i),
      .size_sel_i   (size_sel_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rd_addr_i    (rd_addr_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .mem_err_i    (mem_err_i),
      .stall_o      (stall_o),
`ifdef MISALIGN_TRAP_EN
      .misalign_o   (misalign_o),
`endif
      .wb_valid_o   (wb_valid_o),
      .wb_data_o    (wb_data_o),
      .wb_rd_o      (wb_rd_o),
      .lsu_err_o    (lsu_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n === 1'b1 && (wb_valid_o === 1'b1 || lsu_err_o === 1'b1)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_event", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("sb_err_pulse", {31'd0, lsu_err_o}, {31'd0, e.is_err});
            check("sb_wb_pulse", {31'd0, wb_valid_o}, {31'd0, !e.is_err});
            if (!e.is_err) begin
               check("sb_wb_data", wb_data_o, e.data);
               check("sb_wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // rv_dly < 0 means the bus never answers.
   task automatic access(input logic ld, input logic st, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input logic err,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
      int   stalls;
      int   w;
      logic to;
      exp_t e;
      to     = (rv_dly < 0);
      stalls = 0;
      if (to || err) begin
         e.is_err = 1'b1; e.data = '0; e.rd = '0; sb.push_back(e);
      end else if (ld) begin
         e.is_err = 1'b0; e.data = exp_wb; e.rd = rd; sb.push_back(e);
      end
      load_req_i = ld; store_req_i = st; size_sel_i = sz;
      addr_i = a; wdata_i = wd; rd_addr_i = rd;
      #1;
      check("stall_c0", {31'd0, stall_o}, 32'd1);
      check("no_req_c0", {31'd0, mem_req_o}, 32'd0);
      stalls++;
      tick();
      load_req_i = 1'b0; store_req_i = 1'b0;
      addr_i = $urandom; wdata_i = $urandom; size_sel_i = 3'($urandom); rd_addr_i = 5'($urandom);
      for (int i = 0; i <= gnt_dly; i++) begin
         check("req_held", {31'd0, mem_req_o}, 32'd1);
         check("req_addr", mem_addr_o, exp_addr);
         check("req_be", {28'd0, mem_be_o}, {28'd0, exp_be});
         check("req_we", {31'd0, mem_we_o}, {31'd0, !ld});
         if (!ld) check("req_wdata", mem_wdata_o, exp_wdata);
         if (stall_o) stalls++;
         if (i == gnt_dly) mem_gnt_i = 1'b1;
         tick();
         mem_gnt_i = 1'b0;
      end
      if (to) begin
         w = 0;
         while (stall_o === 1'b1 && w < 400) begin
            w++;
            tick();
         end
         check("timeout_wait_cycles", w, TO_CYC);
         stalls += w;
      end else begin
         for (int j = 0; j <= rv_dly; j++) begin
            check("req_low_in_wait", {31'd0, mem_req_o}, 32'd0);
            if (stall_o) stalls++;
            if (j == rv_dly) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
            end
            tick();
            mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
         end
      end
      check("stall_released", {31'd0, stall_o}, 32'd0);
      check("wb_valid_timing", {31'd0, wb_valid_o}, {31'd0, ld && !err && !to});
      check("err_timing", {31'd0, lsu_err_o}, {31'd0, err || to});
      check("stall_cycles", stalls, to ? (2 + gnt_dly + TO_CYC) : (3 + gnt_dly + rv_dly));
      tick();
      check("wb_one_cycle", {31'd0, wb_valid_o}, 32'd0);
      check("err_one_cycle", {31'd0, lsu_err_o}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      load_req_i = 0; store_req_i = 0; size_sel_i = 0; addr_i = 0; wdata_i = 0; rd_addr_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_req", {31'd0, mem_req_o}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      check("rst_err", {31'd0, lsu_err_o}, 32'd0);
`ifdef MISALIGN_TRAP_EN
      check("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      //     ld st size    addr      wdata         rd  g  r  rdata         err addr      be       wdata         wb
      access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0,  0, 0, 32'h0,        0, 32'h104, 4'b1111, 32'hDEADBEEF, 32'h0);
      access(1, 0, 3'b000, 32'h103, 32'h0,        5,  0, 0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80);
      access(1, 0, 3'b100, 32'h103, 32'h0,        6,  0, 0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080);
      access(0, 1, 3'b001, 32'h102, 32'hABCD1234, 0,  4, 0, 32'h0,        0, 32'h100, 4'b1100, 32'h12341234, 32'h0);
      access(1, 0, 3'b001, 32'h002, 32'h0,        9,  1, 2, 32'h80011234, 0, 32'h000, 4'b1100, 32'h0,        32'hFFFF8001);
      access(1, 0, 3'b101, 32'h000, 32'h0,        10, 0, 1, 32'h1234ABCD, 0, 32'h000, 4'b0011, 32'h0,        32'h0000ABCD);
      access(0, 1, 3'b000, 32'h101, 32'h000000A5, 0,  0, 0, 32'h0,        0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
      access(1, 1, 3'b010, 32'h010, 32'hFFFFFFFF, 11, 0, 0, 32'h11223344, 0, 32'h010, 4'b1111, 32'h0,        32'h11223344);
      access(1, 0, 3'b111, 32'h020, 32'h0,        12, 0, 0, 32'h55667788, 0, 32'h020, 4'b1111, 32'h0,        32'h55667788);
      access(0, 1, 3'b011, 32'h044, 32'h0BADF00D, 0,  0, 0, 32'h0,        0, 32'h044, 4'b1111, 32'h0BADF00D, 32'h0);
      access(1, 0, 3'b010, 32'h030, 32'h0,        13, 0, 1, 32'h99999999, 1, 32'h030, 4'b1111, 32'h0,        32'h0);
      access(0, 1, 3'b010, 32'h034, 32'h13572468, 0,  1, 0, 32'h0,        1, 32'h034, 4'b1111, 32'h13572468, 32'h0);
      access(1, 0, 3'b010, 32'h040, 32'h0,        14, 0, -1, 32'h0,       0, 32'h040, 4'b1111, 32'h0,        32'h0);

      // Reset in the middle of WAIT; the stale rvalid must be ignored.
      load_req_i = 1; size_sel_i = 3'b010; addr_i = 32'h200; rd_addr_i = 7;
      tick();
      load_req_i = 0; mem_gnt_i = 1;
      tick();
      mem_gnt_i = 0;
      tick();
      check("wait_before_rst", {31'd0, stall_o}, 32'd1);
      rst_n = 1'b0;
      tick();
      check("midrst_stall", {31'd0, stall_o}, 32'd0);
      check("midrst_req", {31'd0, mem_req_o}, 32'd0);
      check("midrst_be", {28'd0, mem_be_o}, 32'd0);
      check("midrst_addr", mem_addr_o, 32'd0);
      check("midrst_wb_data", wb_data_o, 32'd0);
      check("midrst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
      rst_n = 1'b1;
      mem_rvalid_i = 1; mem_rdata_i = 32'h77777777;
      tick();
      mem_rvalid_i = 0;
      check("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
      tick();
      check("late_rvalid_no_wb", {31'd0, wb_valid_o}, 32'd0);
      check("late_rvalid_no_err", {31'd0, lsu_err_o}, 32'd0);
      access(1, 0, 3'b010, 32'h050, 32'h0, 31, 0, 0, 32'h600DCAFE, 0, 32'h050, 4'b1111, 32'h0, 32'h600DCAFE);

`ifdef MISALIGN_TRAP_EN
      begin
         int req_seen;
         int trap_seen;
         req_seen = 0; trap_seen = 0;
         load_req_i = 1; size_sel_i = 3'b010; addr_i = 32'h102; rd_addr_i = 3;
         #1;
         check("mis_stall_c0", {31'd0, stall_o}, 32'd1);
         if (mem_req_o) req_seen++;
         tick();
         load_req_i = 0;
         #1;
         check("mis_stall_c1", {31'd0, stall_o}, 32'd0);
         check("mis_pulse_c1", {31'd0, misalign_o}, 32'd1);
         for (int k = 0; k < 6; k++) begin
            if (mem_req_o) req_seen++;
            if (misalign_o) trap_seen++;
            tick();
         end
         check("mis_no_bus_req", req_seen, 0);
         check("mis_single_pulse", trap_seen, 1);
      end
`else
      access(1, 0, 3'b010, 32'h102, 32'h0, 3, 0, 0, 32'hCAFEF00D, 0, 32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
`endif

      repeat (2) tick();
      check("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
